// File: rtl/fp8_line_delay_ram_if.sv
// Stream handshake bundle for fp8_line_delay_ram.
// master: the producer/consumer environment; slave: the delay RAM itself.
interface fp8_line_delay_ram_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/fp8_line_delay_ram.sv
// fp8_line_delay_ram: one-line circular delay buffer for FP8 samples.
// Each accepted byte is written at the shared pointer while the byte stored
// there one line earlier is read into a one-entry output register.
// Optional feature macro: FP8_ZERO_FILL_EN -- while the first line is still
// filling, every accept emits an 8'h00 padding sample instead of nothing.
module fp8_line_delay_ram #(
  parameter int LINE_MAX = 1024,
  parameter int AW       = $clog2(LINE_MAX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [AW:0]          line_width,
  fp8_line_delay_ram_if.slave  bus,
  output logic                 line_end,
  output logic                 primed
);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW:0]   LINE_MAX_W = (AW+1)'(LINE_MAX);
  localparam logic [AW:0]   WIDTH_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

  // Out-of-range widths (zero or wider than the RAM) fall back to a full RAM line.
  function automatic logic [AW:0] clamp_width(input logic [AW:0] w);
    logic [AW:0] res;
    if ((w == {(AW+1){1'b0}}) || (w > LINE_MAX_W)) begin
      res = LINE_MAX_W;
    end else begin
      res = w;
    end
    return res;
  endfunction

  state_t        state_r;
  logic [AW-1:0] ptr_r;
  logic [AW:0]   width_r;
  logic          alive_r;      // low until the first clock after reset release
  logic          out_valid_r;
  logic [7:0]    out_data_r;
  logic          line_end_r;
  logic          primed_r;
  logic [7:0]    mem_r [LINE_MAX];

  logic          in_ready_s;
  logic          accept_s;
  logic          emit_s;
  logic          last_s;

  // Input ready: closed in reset and on the width-latch cycle, otherwise the output skid decides.
  always_comb begin
    if (!alive_r) begin
      in_ready_s = 1'b0;
`ifdef FP8_ZERO_FILL_EN
    end else begin
      in_ready_s = !out_valid_r || bus.out_ready;
    end
`else
    end else if (state_r == ST_FILL) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = !out_valid_r || bus.out_ready;
    end
`endif
  end

  // Accept/emit decode; flush suppresses the write of a same-cycle sample.
  always_comb begin
    accept_s = bus.in_valid && in_ready_s && !flush;
    last_s   = ({1'b0, ptr_r} == (width_r - WIDTH_ONE));
`ifdef FP8_ZERO_FILL_EN
    emit_s   = accept_s;
`else
    emit_s   = accept_s && (state_r == ST_RUN);
`endif
  end

  // Control FSM, pointer, latched width and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_FILL;
      ptr_r       <= {AW{1'b0}};
      width_r     <= LINE_MAX_W;
      alive_r     <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      line_end_r  <= 1'b0;
      primed_r    <= 1'b0;
    end else if (!alive_r) begin
      // First clock after reset release: capture the line width.
      alive_r    <= 1'b1;
      width_r    <= clamp_width(line_width);
      line_end_r <= 1'b0;
    end else if (flush) begin
      state_r     <= ST_FILL;
      ptr_r       <= {AW{1'b0}};
      width_r     <= clamp_width(line_width);
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      line_end_r  <= 1'b0;
      primed_r    <= 1'b0;
    end else begin
      line_end_r <= accept_s && last_s;
      if (accept_s) begin
        if (last_s) begin
          ptr_r <= {AW{1'b0}};
          if (state_r == ST_FILL) begin
            state_r  <= ST_RUN;
            primed_r <= 1'b1;
          end
        end else begin
          ptr_r <= ptr_r + PTR_ONE;
        end
      end
      if (emit_s) begin
        out_valid_r <= 1'b1;
        // Read-before-write: this picks up the byte stored one line ago.
        if (state_r == ST_RUN) begin
          out_data_r <= mem_r[ptr_r];
        end else begin
          out_data_r <= 8'h00;
        end
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // RAM write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[ptr_r] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign line_end      = line_end_r;
  assign primed        = primed_r;

endmodule

// File: tb/tb_fp8_line_delay_ram.sv
// Scoreboard bench for fp8_line_delay_ram. The reference model keeps the list
// of samples accepted since the last flush/reset; accept number k is expected
// to return sample k-W once k >= W (zero padding before that when
// FP8_ZERO_FILL_EN is defined).
module tb_fp8_line_delay_ram;
  localparam int LINE_MAX = 1024;
  localparam int AW       = 10;
`ifdef FP8_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [AW:0]   line_width;
  logic          line_end;
  logic          primed;

  fp8_line_delay_ram_if bus_if();

  fp8_line_delay_ram #(.LINE_MAX(LINE_MAX), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .line_width (line_width),
    .bus        (bus_if),
    .line_end   (line_end),
    .primed     (primed)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  bit         mdl_alive;
  bit         mdl_le;
  bit         mdl_primed;
  bit         mdl_in_ready;
  int         mdl_w;
  int         mdl_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] hist[$];
  bit         seq_mode;
  logic [7:0] seq_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampw(input int lw);
    return ((lw == 0) || (lw > LINE_MAX)) ? LINE_MAX : lw;
  endfunction

  task automatic model_reset();
    mdl_alive    = 1'b0;
    mdl_le       = 1'b0;
    mdl_primed   = 1'b0;
    mdl_in_ready = 1'b0;
    mdl_cnt      = 0;
    exp_q.delete();
    hist.delete();
  endtask

  // Model update for the upcoming rising edge (called at negedge + 1).
  task automatic model_step();
    int k;
    mdl_le = 1'b0;
    if (!reset) begin
      mdl_alive = 1'b0;
    end else if (!mdl_alive) begin
      mdl_alive = 1'b1;
      mdl_w     = clampw(int'(line_width));
      mdl_cnt   = 0;
      hist.delete();
    end else if (flush) begin
      mdl_w      = clampw(int'(line_width));
      mdl_cnt    = 0;
      mdl_primed = 1'b0;
      hist.delete();
      exp_q.delete();
    end else if (bus_if.in_valid && mdl_in_ready) begin
      k = mdl_cnt;
      if (k >= mdl_w) exp_q.push_back(hist[k - mdl_w]);
      else if (ZF) exp_q.push_back(8'h00);
      hist.push_back(bus_if.in_data);
      if ((k % mdl_w) == (mdl_w - 1)) mdl_le = 1'b1;
      if ((k + 1) >= mdl_w) mdl_primed = 1'b1;
      mdl_cnt++;
      if (seq_mode) seq_val = seq_val + 8'h01;
    end
  endtask

  // Monitor: compare handshake/status outputs and pop the scoreboard on each take.
  always @(negedge clk) begin
    bit ev;
    logic [7:0] e;
    ev = (exp_q.size() != 0);
    if (!mdl_alive) mdl_in_ready = 1'b0;
    else if (!ZF && (mdl_cnt < mdl_w)) mdl_in_ready = 1'b1;
    else mdl_in_ready = !ev || bus_if.out_ready;
    chk("out_valid", 32'(bus_if.out_valid), 32'(ev));
    chk("in_ready", 32'(bus_if.in_ready), 32'(mdl_in_ready));
    chk("line_end", 32'(line_end), 32'(mdl_le));
    chk("primed", 32'(primed), 32'(mdl_primed));
    if (bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(bus_if.out_data), 32'(e));
      end
    end
  end

  task automatic run(input int n, input int pv, input int pr);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      flush            = 1'b0;
      bus_if.in_valid  = ($urandom_range(0, 99) < pv);
      bus_if.out_ready = ($urandom_range(0, 99) < pr);
      bus_if.in_data   = seq_mode ? seq_val : 8'($urandom_range(0, 255));
      @(negedge clk); #1;
      model_step();
    end
  endtask

  task automatic do_flush(input int w);
    @(posedge clk); #1;
    flush            = 1'b1;
    line_width       = (AW+1)'(w);
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 8'($urandom_range(0, 255));
    bus_if.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk); #1;
    model_step();
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    model_step();
  endtask

  initial begin
    reset            = 1'b0;
    flush            = 1'b0;
    line_width       = 11'd4;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'h00;
    bus_if.out_ready = 1'b0;
    seq_mode         = 1'b0;
    seq_val          = 8'h00;
    mdl_w            = LINE_MAX;
    model_reset();
    #1;
    chk("reset_out_data", 32'(bus_if.out_data), 32'h00);
    run(3, 50, 50);
    release_reset();

    // W=4 ordered stream 8'h10.. at full rate
    seq_mode = 1'b1;
    seq_val  = 8'h10;
    run(12, 100, 100);
    // Consumer stall for three clocks, then resume
    run(3, 100, 0);
    run(10, 100, 100);
    seq_mode = 1'b0;
    run(60, 70, 50);

    // W=3 flush mid-line with a valid sample present
    run(2, 100, 100);
    do_flush(3);
    run(3, 100, 100);
    run(40, 80, 60);

    // Reset while the output register holds a sample
    run(3, 100, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus_if.out_data), 32'h00);
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'h0);
    run(3, 60, 60);
    line_width = 11'd4;
    release_reset();
    seq_mode = 1'b1;
    seq_val  = 8'h10;
    run(12, 100, 100);
    seq_mode = 1'b0;

    // W=1 at full throughput
    do_flush(1);
    run(20, 100, 100);
    run(30, 70, 70);

    // Zero and oversize widths both mean a full RAM line
    do_flush(0);
    run(1100, 100, 100);
    do_flush(2000);
    run(1100, 100, 100);

    // Assorted small widths with random traffic
    for (int j = 0; j < 6; j++) begin
      do_flush($urandom_range(1, 9));
      run(50, 75, 65);
    end

    run(6, 0, 100);
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
